// File: rtl/ps2_key_event_mmio.sv
// PS/2 scan-code decoder with an event FIFO and a paddle key bitmap, exposed as three MMIO words.
// Events appear one cycle after the final byte; reads are combinational; a push into a full FIFO with no pop is dropped and sets sticky overflow.
module ps2_key_event_mmio #(
    parameter logic [11:0] BASE_ADDR  = 12'd2000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PTR_W      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_valid,
    input  logic [7:0]  scan_code,
    input  logic [11:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    output logic        mmio_hit,
    output logic [31:0] mmio_q,
    output logic [4:0]  key_state,
    output logic        irq_pending
);

    localparam logic [11:0]    ADDR_EV   = BASE_ADDR;
    localparam logic [11:0]    ADDR_KEY  = BASE_ADDR + 12'd1;
    localparam logic [11:0]    ADDR_STAT = BASE_ADDR + 12'd2;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_t;

    dec_state_t state, state_nxt;
    logic       emit, ev_ext, ev_rel, is_prefix;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count, count_nxt;
    logic             overflow;
    logic             pop, push, drop, clr_ovf;
    logic             data_unused;

    // Store data carries no meaning here; only the strobe matters.
    assign data_unused = ^data;

    assign is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0) || (scan_code == 8'hE1);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        ev_ext    = 1'b0;
        ev_rel    = 1'b0;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      state_nxt = S_EXT;
                    else if (scan_code == 8'hF0) state_nxt = S_BRK;
                    else if (scan_code != 8'hE1) emit = 1'b1;
                end
                S_EXT: begin
                    if (scan_code == 8'hF0)      state_nxt = S_EXT_BRK;
                    else if (scan_code != 8'hE0) begin
                        emit      = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    emit      = !is_prefix;
                    ev_rel    = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    emit      = !is_prefix;
                    ev_ext    = 1'b1;
                    ev_rel    = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop     = wren && (address_dmem == ADDR_EV) && (count != '0);
    assign push    = emit && ((count != FULL_CNT) || pop);
    assign drop    = emit && (count == FULL_CNT) && !pop;
    assign clr_ovf = wren && (address_dmem == ADDR_STAT);

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CNT_ONE;
        else if (pop && !push) count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {ev_ext, ev_rel, scan_code};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count       <= count_nxt;
            irq_pending <= (count_nxt != '0);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_state <= '0;
        end else if (emit) begin
            case ({ev_ext, scan_code})
                9'h01D:  key_state[0] <= !ev_rel;
                9'h01B:  key_state[1] <= !ev_rel;
                9'h175:  key_state[2] <= !ev_rel;
                9'h172:  key_state[3] <= !ev_rel;
                9'h029:  key_state[4] <= !ev_rel;
                default: ;
            endcase
        end
    end

    always_comb begin
        mmio_hit = 1'b0;
        mmio_q   = '0;
        case (address_dmem)
            ADDR_EV: begin
                mmio_hit = 1'b1;
                if (count != '0) mmio_q = {1'b1, 21'b0, mem[rd_ptr]};
            end
            ADDR_KEY: begin
                mmio_hit = 1'b1;
                mmio_q   = {27'b0, key_state};
            end
            ADDR_STAT: begin
                mmio_hit       = 1'b1;
                mmio_q[8]      = overflow;
                mmio_q[PTR_W:0] = count;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_key_event_mmio.sv
// Directed scenarios plus randomized byte/pop/reset traffic, compared against a queue-based event model.
module tb_ps2_key_event_mmio;

    localparam logic [11:0] BASE  = 12'd2000;
    localparam int          DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic [11:0] address_dmem;
    logic        wren;
    logic [31:0] data;
    logic        mmio_hit;
    logic [31:0] mmio_q;
    logic [4:0]  key_state;
    logic        irq_pending;

    ps2_key_event_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PTR_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .address_dmem (address_dmem),
        .wren         (wren),
        .data         (data),
        .mmio_hit     (mmio_hit),
        .mmio_q       (mmio_q),
        .key_state    (key_state),
        .irq_pending  (irq_pending)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: pending prefix bytes, queued events, overflow flag, key bitmap.
    logic [7:0] pfx[$];
    logic [9:0] mq[$];
    bit         m_ovf;
    logic [4:0] m_keys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int key_bit(input bit ext, input logic [7:0] c);
        if (!ext && c == 8'h1D) return 0;
        if (!ext && c == 8'h1B) return 1;
        if ( ext && c == 8'h75) return 2;
        if ( ext && c == 8'h72) return 3;
        if (!ext && c == 8'h29) return 4;
        return -1;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] c, input bit wr,
                              input logic [11:0] a, input bit rst);
        bit has_ext, has_brk, do_emit, ev_ext, ev_rel, pop;
        int pre, kb;
        if (rst) begin
            pfx.delete();
            mq.delete();
            m_ovf  = 0;
            m_keys = '0;
            return;
        end
        has_ext = 0;
        has_brk = 0;
        do_emit = 0;
        ev_ext  = 0;
        ev_rel  = 0;
        foreach (pfx[i]) begin
            if (pfx[i] == 8'hE0) has_ext = 1;
            if (pfx[i] == 8'hF0) has_brk = 1;
        end
        if (v) begin
            if (has_brk) begin
                if (c != 8'hE0 && c != 8'hF0 && c != 8'hE1) begin
                    do_emit = 1;
                    ev_ext  = has_ext;
                    ev_rel  = 1;
                end
                pfx.delete();
            end else if (c == 8'hE0 || c == 8'hF0) begin
                pfx.push_back(c);
            end else if (c == 8'hE1 && !has_ext) begin
                // lone E1 is ignored
            end else begin
                do_emit = 1;
                ev_ext  = has_ext;
                pfx.delete();
            end
        end
        pre = mq.size();
        pop = wr && (a == BASE) && (pre > 0);
        if (pop) void'(mq.pop_front());
        if (wr && a == BASE + 12'd2) m_ovf = 0;
        if (do_emit) begin
            if (pre < DEPTH || pop) mq.push_back({ev_ext, ev_rel, c});
            else                    m_ovf = 1;
            kb = key_bit(ev_ext, c);
            if (kb >= 0) m_keys[kb] = !ev_rel;
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        logic [31:0] w;
        w = '0;
        if (a == BASE) begin
            if (mq.size() > 0) w = {1'b1, 21'b0, mq[0]};
        end else if (a == BASE + 12'd1) begin
            w = {27'b0, m_keys};
        end else if (a == BASE + 12'd2) begin
            w[8]   = m_ovf;
            w[3:0] = 4'(mq.size());
        end
        return w;
    endfunction

    task automatic check_all();
        logic [11:0] addrs[5];
        scan_valid = 1'b0;
        wren       = 1'b0;
        addrs      = '{BASE - 12'd1, BASE, BASE + 12'd1, BASE + 12'd2, BASE + 12'd3};
        chk("key_state", {27'b0, key_state}, {27'b0, m_keys});
        chk("irq_pending", {31'b0, irq_pending}, {31'b0, (mq.size() != 0)});
        foreach (addrs[i]) begin
            address_dmem = addrs[i];
            #1;
            chk("mmio_hit", {31'b0, mmio_hit}, {31'b0, (addrs[i] >= BASE && addrs[i] <= BASE + 12'd2)});
            chk("mmio_q", mmio_q, exp_word(addrs[i]));
        end
    endtask

    task automatic step(input bit v, input logic [7:0] c, input bit wr,
                        input logic [11:0] a, input bit rst);
        reset        = rst;
        scan_valid   = v;
        scan_code    = c;
        wren         = wr;
        address_dmem = a;
        data         = $urandom;
        @(posedge clock);
        model_step(v, c, wr, a, rst);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] q);
        address_dmem = a;
        #1;
        q = mmio_q;
    endtask

    task automatic byte_in(input logic [7:0] c);
        step(1, c, 0, 12'd0, 0);
    endtask

    task automatic pop_ev();
        step(0, 8'h00, 1, BASE, 0);
    endtask

    logic [31:0] q;
    logic [7:0]  pick[8] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'hE1};

    initial begin
        reset = 1'b1; scan_valid = 1'b0; scan_code = '0;
        address_dmem = '0; wren = 1'b0; data = '0;
        m_ovf = 0; m_keys = '0;

        step(0, 8'h00, 0, 12'd0, 1);
        rd(BASE + 12'd2, q); chk("reset_status", q, 32'h0);

        byte_in(8'h1D);
        rd(BASE, q);          chk("tp1_head", q, 32'h8000001D);
        chk("tp1_keys", {27'b0, key_state}, 32'h1);
        rd(BASE + 12'd2, q);  chk("tp1_count", q, 32'h1);
        pop_ev();

        byte_in(8'hE0); byte_in(8'h75);
        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h75);
        pop_ev();
        rd(BASE, q);          chk("tp2_head", q, 32'h80000375);
        chk("tp2_up", {31'b0, key_state[2]}, 32'h0);
        pop_ev();
        rd(BASE + 12'd2, q);  chk("tp2_count", q, 32'h0);

        for (int i = 0; i < 9; i++) byte_in(8'h1C + 8'(i));
        rd(BASE + 12'd2, q);  chk("tp3_status", q, 32'h108);
        rd(BASE, q);          chk("tp3_head", q, 32'h8000001C);
        step(0, 8'h00, 1, BASE + 12'd2, 0);
        rd(BASE + 12'd2, q);  chk("tp3_clear", q, 32'h8);

        step(1, 8'h29, 1, BASE, 0);
        rd(BASE + 12'd2, q);  chk("tp4_status", q, 32'h8);
        chk("tp4_space", {31'b0, key_state[4]}, 32'h1);
        for (int i = 0; i < 7; i++) pop_ev();
        rd(BASE, q);          chk("tp4_last", q, 32'h80000029);
        pop_ev();

        byte_in(8'hF0);
        step(0, 8'h00, 0, 12'd0, 1);
        byte_in(8'h1B);
        rd(BASE, q);          chk("tp5_head", q, 32'h8000001B);
        chk("tp5_s", {31'b0, key_state[1]}, 32'h1);
        pop_ev();

        byte_in(8'hF0); byte_in(8'hE0); byte_in(8'h72);
        rd(BASE + 12'd2, q);  chk("tp6_count", q, 32'h1);
        rd(BASE, q);          chk("tp6_head", q, 32'h80000072);
        chk("tp6_down", {31'b0, key_state[3]}, 32'h0);
        pop_ev();
        pop_ev();
        rd(BASE + 12'd2, q);  chk("tp6_empty_count", q, 32'h0);
        rd(BASE, q);          chk("tp6_empty_head", q, 32'h0);

        for (int ph = 0; ph < 6; ph++) begin
            int pop_pct = 10 + ph * 15;
            for (int n = 0; n < 500; n++) begin
                bit          v, wr, rst;
                logic [7:0]  c;
                logic [11:0] a;
                v   = ($urandom_range(0, 2) != 0);
                c   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pick[$urandom_range(0, 7)];
                wr  = ($urandom_range(0, 99) < pop_pct);
                a   = BASE + 12'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0 && wr) a = BASE;
                rst = ($urandom_range(0, 299) == 0);
                step(v, c, wr, a, rst);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
